branch_redirect_ctrl: RTL and testbench

//  Sequences the front end after a taken branch/jump. Takes the registered br_taken
//  and the target from the branch-condition stage, squashes younger instructions for

---
 rtl/branch_redirect_ctrl.sv | 125 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer for taken branches and jumps.
// A taken branch first squashes the younger instructions for FLUSH_CYCLES cycles. It then
// holds a PC redirect to the fetch side until fetch accepts it.
// Ports:
//   clk            core clock, all state on rising edge
//   reset          asynchronous, active-low
//   br_taken       taken branch/jump pulse from the branch-condition stage
//   br_target      target PC, valid with br_taken
//   fetch_ready    fetch/I-cache accepts the redirect this cycle
//   abort          external kill, cancels any sequence in progress
//   flush          squash IF/ID and ID/EX
//   redirect_valid redirect_pc valid, held until accepted
//   redirect_pc    captured branch target
//   busy           high whenever a sequence is in progress
//   redirect_cnt   saturating count of accepted redirects
module branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             fetch_ready,
  input  logic             abort,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int unsigned FcntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StFlush    = 2'b01,
    StRedirect = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    target_q, target_d;
  logic [FcntW-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      target_q <= '0;
      fcnt_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    fcnt_d   = fcnt_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        // abort wins over a simultaneous branch
        if (!abort && br_taken) begin
          target_d = br_target;
          fcnt_d   = FcntW'(FLUSH_CYCLES - 1);
          state_d  = StFlush;
        end
      end
      StFlush: begin
        // br_taken here belongs to a squashed instruction, so it is ignored
        if (abort) begin
          state_d = StIdle;
        end else if (fcnt_q == '0) begin
          state_d = StRedirect;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      StRedirect: begin
        if (abort) begin
          state_d = StIdle;
        end else if (fetch_ready) begin
          state_d = StIdle;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    flush          = 1'b0;
    redirect_valid = 1'b0;
    busy           = 1'b0;
    case (state_q)
      StFlush: begin
        flush = 1'b1;
        busy  = 1'b1;
      end
      StRedirect: begin
        redirect_valid = 1'b1;
        busy           = 1'b1;
      end
      default: begin
        flush          = 1'b0;
        redirect_valid = 1'b0;
        busy           = 1'b0;
      end
    endcase
  end

  assign redirect_pc  = target_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  // Instance 1: default parameters
  logic        br_taken1, fetch_ready1, abort1;
  logic [31:0] br_target1;
  logic        flush1, rv1, busy1;
  logic [31:0] pc1;
  logic [15:0] cnt1;

  // Instance 2: CNT_W=2, FLUSH_CYCLES=1
  logic        br_taken2, fetch_ready2, abort2;
  logic [31:0] br_target2;
  logic        flush2, rv2, busy2;
  logic [31:0] pc2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc1[$];
  logic [31:0] exp_pc2[$];
  logic [31:0] e1, e2;

  always #5 clk = ~clk;

  branch_redirect_ctrl u_dut1 (
    .clk            (clk),
    .reset          (reset),
    .br_taken       (br_taken1),
    .br_target      (br_target1),
    .fetch_ready    (fetch_ready1),
    .abort          (abort1),
    .flush          (flush1),
    .redirect_valid (rv1),
    .redirect_pc    (pc1),
    .busy           (busy1),
    .redirect_cnt   (cnt1)
  );

  branch_redirect_ctrl #(
    .XLEN         (32),
    .FLUSH_CYCLES (1),
    .CNT_W        (2)
  ) u_dut2 (
    .clk            (clk),
    .reset          (reset),
    .br_taken       (br_taken2),
    .br_target      (br_target2),
    .fetch_ready    (fetch_ready2),
    .abort          (abort2),
    .flush          (flush2),
    .redirect_valid (rv2),
    .redirect_pc    (pc2),
    .busy           (busy2),
    .redirect_cnt   (cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: an accepted redirect must match the oldest expected target
  always @(negedge clk) begin
    if (reset && rv1 && fetch_ready1 && !abort1) begin
      if (exp_pc1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected redirect: got 0x%08h expected none", pc1);
      end else begin
        e1 = exp_pc1.pop_front();
        check("dut1 accepted pc", pc1, e1);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && rv2 && fetch_ready2 && !abort2) begin
      if (exp_pc2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2 unexpected redirect: got 0x%08h expected none", pc2);
      end else begin
        e2 = exp_pc2.pop_front();
        check("dut2 accepted pc", pc2, e2);
      end
    end
  end

  initial begin
    reset = 1'b0;
    br_taken1 = 1'b0; br_target1 = '0; fetch_ready1 = 1'b0; abort1 = 1'b0;
    br_taken2 = 1'b0; br_target2 = '0; fetch_ready2 = 1'b1; abort2 = 1'b0;
    #2;
    check("reset flush", {31'd0, flush1}, 32'd0);
    check("reset busy", {31'd0, busy1}, 32'd0);
    check("reset rv", {31'd0, rv1}, 32'd0);
    check("reset pc", pc1, 32'd0);
    check("reset cnt", {16'd0, cnt1}, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // Basic redirect, FLUSH_CYCLES=2, fetch ready
    br_taken1 = 1'b1; br_target1 = 32'h100; fetch_ready1 = 1'b1;
    exp_pc1.push_back(32'h100);
    step();
    br_taken1 = 1'b0;
    @(negedge clk);
    check("t2 flush T+1", {31'd0, flush1}, 32'd1);
    check("t2 busy T+1", {31'd0, busy1}, 32'd1);
    check("t2 rv T+1", {31'd0, rv1}, 32'd0);
    step();
    @(negedge clk);
    check("t2 flush T+2", {31'd0, flush1}, 32'd1);
    step();
    @(negedge clk);
    check("t2 flush T+3", {31'd0, flush1}, 32'd0);
    check("t2 rv T+3", {31'd0, rv1}, 32'd1);
    check("t2 pc T+3", pc1, 32'h100);
    step();
    @(negedge clk);
    check("t2 busy T+4", {31'd0, busy1}, 32'd0);
    check("t2 cnt", {16'd0, cnt1}, 32'd1);

    // Redirect held while fetch is stalled, target input toggles
    step();
    br_taken1 = 1'b1; br_target1 = 32'h100; fetch_ready1 = 1'b0;
    exp_pc1.push_back(32'h100);
    step();
    br_taken1 = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      fetch_ready1 = (i == 3);
      br_target1 = 32'hdead_0000 ^ i;
      @(negedge clk);
      check("t3 rv held", {31'd0, rv1}, 32'd1);
      check("t3 pc held", pc1, 32'h100);
      step();
    end
    @(negedge clk);
    check("t3 rv dropped", {31'd0, rv1}, 32'd0);
    check("t3 cnt", {16'd0, cnt1}, 32'd2);

    // Branches during FLUSH and on the accept cycle are ignored
    step();
    br_taken1 = 1'b1; br_target1 = 32'h100; fetch_ready1 = 1'b1;
    exp_pc1.push_back(32'h100);
    step();
    br_target1 = 32'h200;
    @(negedge clk);
    check("t4 flush T+1", {31'd0, flush1}, 32'd1);
    step();
    br_taken1 = 1'b0;
    step();
    br_taken1 = 1'b1;
    @(negedge clk);
    check("t4 pc T+3", pc1, 32'h100);
    step();
    br_taken1 = 1'b0;
    @(negedge clk);
    check("t4 busy after accept", {31'd0, busy1}, 32'd0);
    check("t4 pc kept", pc1, 32'h100);
    check("t4 cnt", {16'd0, cnt1}, 32'd3);
    step();
    @(negedge clk);
    check("t4 still idle", {31'd0, busy1}, 32'd0);

    // Abort in FLUSH
    step();
    br_taken1 = 1'b1; br_target1 = 32'h300;
    step();
    br_taken1 = 1'b0; abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    @(negedge clk);
    check("t5a busy", {31'd0, busy1}, 32'd0);
    check("t5a flush", {31'd0, flush1}, 32'd0);
    step();
    @(negedge clk);
    check("t5a rv", {31'd0, rv1}, 32'd0);
    check("t5a cnt", {16'd0, cnt1}, 32'd3);

    // abort together with br_taken in IDLE
    step();
    br_taken1 = 1'b1; abort1 = 1'b1; br_target1 = 32'h380;
    step();
    br_taken1 = 1'b0; abort1 = 1'b0;
    @(negedge clk);
    check("t5b busy", {31'd0, busy1}, 32'd0);

    // Abort in REDIRECT with fetch ready
    step();
    br_taken1 = 1'b1; br_target1 = 32'h400; fetch_ready1 = 1'b1;
    step();
    br_taken1 = 1'b0;
    step();
    step();
    abort1 = 1'b1;
    @(negedge clk);
    check("t5c rv", {31'd0, rv1}, 32'd1);
    step();
    abort1 = 1'b0;
    @(negedge clk);
    check("t5c busy", {31'd0, busy1}, 32'd0);
    check("t5c cnt", {16'd0, cnt1}, 32'd3);

    // Async reset mid-FLUSH, no clock edge
    step();
    br_taken1 = 1'b1; br_target1 = 32'h500;
    step();
    br_taken1 = 1'b0;
    @(negedge clk);
    check("t1 flush before", {31'd0, flush1}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t1 flush", {31'd0, flush1}, 32'd0);
    check("t1 busy", {31'd0, busy1}, 32'd0);
    check("t1 rv", {31'd0, rv1}, 32'd0);
    check("t1 cnt", {16'd0, cnt1}, 32'd0);
    check("t1 pc", pc1, 32'd0);
    step();
    reset = 1'b1;
    step();

    // Small counter saturates, single-cycle flush
    for (int i = 0; i < 5; i++) begin
      br_taken2 = 1'b1; br_target2 = 32'h1000 + 32'(i * 4);
      exp_pc2.push_back(32'h1000 + 32'(i * 4));
      step();
      br_taken2 = 1'b0;
      @(negedge clk);
      check("t6 flush", {31'd0, flush2}, 32'd1);
      step();
      @(negedge clk);
      check("t6 flush one cycle", {31'd0, flush2}, 32'd0);
      check("t6 rv", {31'd0, rv2}, 32'd1);
      step();
      @(negedge clk);
      check("t6 cnt", {30'd0, cnt2}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    check("t6 final cnt", {30'd0, cnt2}, 32'd3);

    step();
    check("dut1 queue drained", 32'(exp_pc1.size()), 32'd0);
    check("dut2 queue drained", 32'(exp_pc2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
